// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port identifiers and the write-mask value that denotes a read.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,  // no access in flight
        ARB_ACCESS = 2'd1,  // mem_* outputs present one access
        ARB_RESP   = 2'd2   // memory data valid, ack to the granted port
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;  // processor memory port
    localparam logic PORT_AUX = 1'b1;  // loader / debug master

    localparam logic [3:0] WMASK_READ = 4'b0000;

endpackage : mem_arb_pkg

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Combinational two-way round-robin picker.
//
// Ports:
//   eligible[1:0]  in   one bit per port, 1 = port may be granted now
//   last           in   port granted most recently
//   valid          out  at least one port is eligible
//   winner         out  selected port (meaningful only when valid=1)
// -----------------------------------------------------------------------------
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |eligible;
        winner = PORT_CPU;
        if (eligible == 2'b11) begin
            // Contention: the port that did not win last time goes first.
            winner = ~last;
        end else if (eligible[PORT_AUX]) begin
            winner = PORT_AUX;
        end
    end

endmodule : arb_rr2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported Memory between two requesters with round-robin
// fairness. Each access takes an ACCESS cycle (registered strobe/mask to the
// Memory) followed by a RESP cycle (one-cycle ack, read data valid). A waiting
// port is granted straight out of RESP, so two busy ports get one access
// every two cycles.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m0_* / m1_*               requester ports: req/addr/wmask/wdata in,
//                             rdata/ack out (wmask=0 means read)
//   mem_addr, mem_rstrb,      registered Memory request outputs
//   mem_wmask, mem_wdata
//   mem_rdata                 Memory read data, valid the cycle after rstrb
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_wmask,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_wmask,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [3:0]        mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rstrb_q, mem_rstrb_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;

    logic [1:0]        eligible;
    logic              pick_valid;
    logic              pick_winner;

    // In RESP the port being acked still holds req this cycle; masking it out
    // keeps it from being re-granted before it has seen its own ack.
    always_comb begin
        eligible = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                eligible[PORT_CPU] = m0_req;
                eligible[PORT_AUX] = m1_req;
            end
            ARB_RESP: begin
                eligible[PORT_CPU] = m0_req && (grant_q != PORT_CPU);
                eligible[PORT_AUX] = m1_req && (grant_q != PORT_AUX);
            end
            default: eligible = 2'b00;
        endcase
    end

    arb_rr2 u_rr2 (
        .eligible (eligible),
        .last     (last_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rstrb_d = 1'b0;
        mem_wmask_d = WMASK_READ;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;

        case (state_q)
            ARB_ACCESS: begin
                // Strobe/mask drop back to their defaults; addr/wdata hold.
                state_d  = ARB_RESP;
                m0_ack_d = (grant_q == PORT_CPU);
                m1_ack_d = (grant_q == PORT_AUX);
            end
            ARB_IDLE, ARB_RESP: begin
                if (pick_valid) begin
                    state_d = ARB_ACCESS;
                    grant_d = pick_winner;
                    last_d  = pick_winner;
                    if (pick_winner == PORT_AUX) begin
                        mem_addr_d  = m1_addr;
                        mem_wdata_d = m1_wdata;
                        mem_wmask_d = m1_wmask;
                        mem_rstrb_d = (m1_wmask == WMASK_READ);
                    end else begin
                        mem_addr_d  = m0_addr;
                        mem_wdata_d = m0_wdata;
                        mem_wmask_d = m0_wmask;
                        mem_rstrb_d = (m0_wmask == WMASK_READ);
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= PORT_CPU;
            last_q      <= PORT_AUX;  // port 0 wins the first tie
            mem_addr_q  <= '0;
            mem_rstrb_q <= 1'b0;
            mem_wmask_q <= WMASK_READ;
            mem_wdata_q <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_rstrb_q <= mem_rstrb_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rstrb = mem_rstrb_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;

    // Read data is only meaningful in the requester's ack cycle.
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A small word memory model answers the
// arbiter's Memory port; expected acks (port and read data) are queued when a
// request is driven and popped when an ack appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct packed {
        logic        port;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [3:0]  m0_wmask = '0;
    logic [31:0] m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;

    logic        m1_req = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [3:0]  m1_wmask = '0;
    logic [31:0] m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;

    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem_arr [0:63] = '{4: 32'hDEADBEEF, 8: 32'h5555_0000, default: 32'h0};

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    bit   ack_now = 1'b0;
    bit   ack_port = 1'b0;
    bit   hold_reqs = 1'b0;
    bit   drop0 = 1'b0;
    bit   drop1 = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wmask  (m0_wmask),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wmask  (m1_wmask),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data registered one cycle after rstrb, byte writes.
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem_arr[mem_addr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Raise a request on a port; queue the expected ack when one should come.
    task automatic drive(input bit port, input logic [31:0] addr, input logic [3:0] wmask,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit expect_ack);
        exp_t e;
        if (port) begin
            m1_req = 1'b1; m1_addr = addr; m1_wmask = wmask; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_addr = addr; m0_wmask = wmask; m0_wdata = wdata;
        end
        e.port    = port;
        e.is_read = (wmask == 4'b0000);
        e.rdata   = exp_rdata;
        if (expect_ack) sb_q.push_back(e);
    endtask

    // Advance one cycle, sample at the falling edge, retire any ack against
    // the scoreboard and drop the acked request in the following cycle.
    task automatic tick();
        exp_t        e;
        bit          port;
        logic [31:0] rdata;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ack_now = 1'b0;
        if (drop0) begin m0_req = 1'b0; drop0 = 1'b0; end
        if (drop1) begin m1_req = 1'b0; drop1 = 1'b0; end
        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            port     = (m1_ack === 1'b1);
            ack_now  = 1'b1;
            ack_port = port;
            ack_cnt++;
            checks++;
            if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
                errors++;
                $display("FAIL sb_dual_ack cycle=%0d both acks high, required one", cyc);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack cycle=%0d port=%0d, required no ack", cyc, port);
            end else begin
                e = sb_q.pop_front();
                if (e.port != port) begin
                    errors++;
                    $display("FAIL sb_port cycle=%0d got port %0d required port %0d", cyc, port, e.port);
                end else if (e.is_read) begin
                    checks++;
                    rdata = port ? m1_rdata : m0_rdata;
                    if (rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_rdata port=%0d got %h required %h", port, rdata, e.rdata);
                    end
                end
            end
            if (!hold_reqs) begin
                if (port) drop1 = 1'b1; else drop0 = 1'b1;
            end
        end
    endtask

    task automatic settle();
        repeat (3) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending acks required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_rstrb !== 1'b0 || mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL reset_strobes got rstrb=%b wmask=%b required 0/0000", mem_rstrb, mem_wmask);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr_data got addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_acks got %b%b required 00", m1_ack, m0_ack);
        end
        rst = 1'b0;
    endtask

    // Both ports raise together straight out of reset: port 0 first, port 1
    // granted from RESP with no idle cycle in between.
    task automatic test_simultaneous();
        drive(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        drive(1'b1, 32'h30, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
        tick();
        checks++;
        if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10 || mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL simul_t1 got rstrb=%b addr=%h wmask=%b required 1/10/0000", mem_rstrb, mem_addr, mem_wmask);
        end
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_t2 got acks %b%b required 01", m1_ack, m0_ack);
        end
        tick();
        checks++;
        if (mem_wmask !== 4'hF || mem_rstrb !== 1'b0 || mem_addr !== 32'h30 || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL simul_t3 got wmask=%b rstrb=%b addr=%h wdata=%h required 1111/0/30/12345678",
                     mem_wmask, mem_rstrb, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_t4 got acks %b%b required 10", m1_ack, m0_ack);
        end
        settle();
    endtask

    task automatic test_single_read();
        drive(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        tick();
        checks++;
        if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL read_strobe got rstrb=%b addr=%h required 1/10", mem_rstrb, mem_addr);
        end
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || mem_rstrb !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_ack got ack0=%b ack1=%b rstrb=%b rdata=%h required 1/0/0/deadbeef",
                     m0_ack, m1_ack, mem_rstrb, m0_rdata);
        end
        tick();
        checks++;
        if (m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL read_ack_pulse got ack0=%b required 0", m0_ack);
        end
        settle();
    endtask

    task automatic test_single_write();
        drive(1'b1, 32'h20, 4'b0011, 32'h0000_ABCD, 32'h0, 1'b1);
        tick();
        checks++;
        if (mem_wmask !== 4'b0011 || mem_rstrb !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL write_t1 got wmask=%b rstrb=%b addr=%h wdata=%h required 0011/0/20/0000abcd",
                     mem_wmask, mem_rstrb, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (mem_wmask !== 4'h0 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_t2 got wmask=%b ack1=%b ack0=%b required 0000/1/0", mem_wmask, m1_ack, m0_ack);
        end
        settle();
        // Only the low two bytes were enabled; the upper half keeps its old value.
        drive(1'b0, 32'h20, 4'h0, 32'h0, 32'h5555_ABCD, 1'b1);
        tick();
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata[15:0] !== 16'hABCD) begin
            errors++;
            $display("FAIL write_readback got ack=%b rdata=%h required 1/xxxxabcd", m0_ack, m0_rdata);
        end
        settle();
    endtask

    // Both ports hold req; last grant was port 0, so port 1 leads and the
    // acks must alternate 1,0,1,0,... at one per two cycles.
    task automatic test_fairness();
        exp_t e;
        int   start;
        int   first_cyc;
        int   last_cyc;
        hold_reqs = 1'b1;
        drive(1'b1, 32'h30, 4'h0, 32'h0, 32'h1234_5678, 1'b1);
        drive(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        for (int i = 2; i < 8; i++) begin
            e.port    = (i % 2 == 0);
            e.is_read = 1'b1;
            e.rdata   = e.port ? 32'h1234_5678 : 32'hDEADBEEF;
            sb_q.push_back(e);
        end
        start     = ack_cnt;
        first_cyc = 0;
        last_cyc  = 0;
        for (int n = 0; n < 60 && ack_cnt < start + 8; n++) begin
            tick();
            if (ack_now) begin
                if (ack_cnt == start + 1) first_cyc = cyc;
                if (ack_cnt == start + 7) begin
                    // Stop after the eighth access: release holds, drop this port now.
                    hold_reqs = 1'b0;
                    if (ack_port) m1_req = 1'b0; else m0_req = 1'b0;
                end
                if (ack_cnt == start + 8) last_cyc = cyc;
            end
        end
        hold_reqs = 1'b0;
        checks++;
        if (ack_cnt != start + 8) begin
            errors++;
            $display("FAIL fair_count got %0d acks required 8", ack_cnt - start);
        end
        checks++;
        if (last_cyc - first_cyc != 14) begin
            errors++;
            $display("FAIL fair_throughput got %0d cycles first-to-eighth ack required 14", last_cyc - first_cyc);
        end
        settle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (mem_rstrb !== 1'b0 || mem_wmask !== 4'h0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle=%0d got rstrb=%b wmask=%b acks=%b%b required 0/0000/00",
                         i, mem_rstrb, mem_wmask, m1_ack, m0_ack);
            end
        end
    endtask

    // Reset lands in the middle of an ACCESS cycle (a read, then a write).
    task automatic test_reset_mid();
        logic [3:0] wm;
        for (int ph = 0; ph < 2; ph++) begin
            wm = (ph == 1) ? 4'hF : 4'h0;
            drive(1'b0, 32'h40, wm, 32'hCAFE_F00D, 32'h0, 1'b0);
            tick();
            checks++;
            if (mem_rstrb !== (ph == 0) || mem_wmask !== wm) begin
                errors++;
                $display("FAIL rstmid_pre ph=%0d got rstrb=%b wmask=%b required %b/%b", ph, mem_rstrb, mem_wmask, ph == 0, wm);
            end
            rst = 1'b1;
            #1;
            checks++;
            if (mem_rstrb !== 1'b0 || mem_wmask !== 4'h0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_async ph=%0d got rstrb=%b wmask=%b acks=%b%b required 0/0000/00",
                         ph, mem_rstrb, mem_wmask, m1_ack, m0_ack);
            end
            m0_req = 1'b0;
            drive(1'b1, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
            tick();
            tick();
            checks++;
            if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_ack ph=%0d got acks %b%b required 00", ph, m1_ack, m0_ack);
            end
            rst = 1'b0;
            tick();
            checks++;
            if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10) begin
                errors++;
                $display("FAIL rstmid_restart ph=%0d got rstrb=%b addr=%h required 1/10", ph, mem_rstrb, mem_addr);
            end
            tick();
            checks++;
            if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_ack ph=%0d got acks %b%b required 10", ph, m1_ack, m0_ack);
            end
            settle();
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_read();
        test_single_write();
        test_fairness();
        test_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-ported Memory block between two requesters. Port 0 is the Processor's memory port; port 1 is a secondary master such as a UART program loader or debug port. It serialises requests with round-robin fairness and drives the Memory's addr/rstrb/wmask/wdata interface as registered outputs. It returns read data and a one-cycle acknowledge to the winning requester, so the Processor stalls on its port until acknowledged.

Parameters:
ADDR_W, 32, byte-address width on all ports
DATA_W, 32, data width; fixed 4-byte write mask

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
m0_req  in  1  port-0 request; held high with addr/wmask/wdata stable until m0_ack
m0_addr  in  ADDR_W  port-0 byte address
m0_wmask  in  4  port-0 byte write enables; 0 = read
m0_wdata  in  DATA_W  port-0 write data
m0_rdata  out  DATA_W  port-0 read data, valid when m0_ack=1 on a read
m0_ack  out  1  port-0 one-cycle completion pulse
m1_req, m1_addr, m1_wmask, m1_wdata, m1_rdata, m1_ack  same as port 0, for port 1
mem_addr  out  ADDR_W  address to Memory (registered)
mem_rstrb  out  1  one-cycle read strobe to Memory (registered)
mem_wmask  out  4  byte write enables to Memory, non-zero for one cycle (registered)
mem_wdata  out  DATA_W  write data to Memory (registered)
mem_rdata  in  DATA_W  Memory read data, valid the cycle after mem_rstrb

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, grant=0, last=1 (port 0 wins the first tie), mem_addr=0, mem_rstrb=0, mem_wmask=0, mem_wdata=0, m0_ack=0, m1_ack=0.
- States:
  - IDLE: no access in flight.
  - ACCESS: mem_* outputs present one access.
  - RESP: Memory data valid; ack asserted.
- Eligibility:
  - In IDLE, a port is eligible if its mN_req=1.
  - In RESP, only the port not being acked is eligible. The acked requester still has req high in that cycle and must not be re-granted.
- Pick rule:
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port != last.
- On grant, at the clock edge:
  - Register mem_addr, mem_wdata and mem_wmask from the winner.
  - Set mem_rstrb = (winner wmask == 0).
  - Set grant = winner and last = winner.
  - Go to ACCESS.
- IDLE with no eligible port: stay in IDLE with mem_rstrb=0 and mem_wmask=0.
- ACCESS: lasts exactly one cycle, during which the Memory samples its inputs. At the edge, clear mem_rstrb and mem_wmask (mem_addr and mem_wdata hold), then go to RESP.
- RESP:
  - Assert m<grant>_ack=1 for exactly this cycle; the other ack stays 0.
  - If the other port is eligible, grant it as above and go to ACCESS (back-to-back). Otherwise go to IDLE.
- Latency: request seen in IDLE at cycle T gives mem strobe in T+1 and ack in T+2. Throughput is one access per 2 cycles when both ports are busy.
- Read data: m0_rdata and m1_rdata are combinational copies of mem_rdata. They are meaningful only in the ack cycle of a read; for writes, rdata is don't-care.
- Requester rule: drop mN_req, or present a new request, in the cycle after ack. A request held continuously is served again on the next free slot, alternating with the other port if it is requesting.
- Request withdrawal: mN_req dropped before grant is simply not served. Dropping req after grant is a protocol violation; the access still completes and the ack is still issued.
- Reset mid-operation: all registers return to reset values immediately (asynchronously). The in-flight access is abandoned, no ack is issued, and mem_rstrb/mem_wmask deassert without waiting for a clock edge.
- Address: passed through at full width. Word selection (addr[..:2]) is the Memory's job; no alignment checking.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding ARB_IDLE, ARB_ACCESS, ARB_RESP.
  - Port IDs PORT_CPU=0, PORT_AUX=1.
  - WMASK_READ=4'b0000.
- Sub-module arb_rr2: combinational 2-way round-robin picker.
  - Inputs: eligible[1:0], last.
  - Outputs: valid, winner.
- The FSM and output registers stay in mem_arbiter.

Test Plan:
- Single read: m0 read at addr 0x10; Memory returns 0xDEADBEEF → mem_rstrb=1 only in T+1 with mem_addr=0x10; m0_ack=1 only in T+2 with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- Single write: m1 write addr 0x20, wmask 4'b0011, wdata 0x0000ABCD → mem_wmask=4'b0011 for exactly one cycle, mem_rstrb=0; m1_ack in T+2; a later read of 0x20 returns the low half 0xABCD.
- Simultaneous: both requests first raised in the same cycle out of reset → m0 served first (ack T+2), then m1 back-to-back (mem strobe T+3, ack T+4), with no IDLE cycle between.
- Fairness: both ports hold req continuously for 8 accesses → acks alternate 0,1,0,1…; no port gets two consecutive grants while the other is requesting.
- Reset mid-access: assert rst during ACCESS → mem_rstrb, mem_wmask and both acks go 0 immediately. After release, state is IDLE; a pending m1-only request is served with ack 2 cycles later.
- Idle: no requests for 20 cycles → mem_rstrb=0 and mem_wmask=0 throughout, acks 0.
